// File: rtl/threshold_gather.sv
// Binarises a grayscale pixel stream against a frame-latched threshold and gathers 4 results per output group.
// Optional foreground counter enabled by defining FG_COUNT_EN.
module threshold_gather #(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned FRAME_PIXELS = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PIX_W-1:0] threshold,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             pixel_out_0,
  output logic             pixel_out_1,
  output logic             pixel_out_2,
  output logic             pixel_out_3,
  output logic             m_last,
  output logic             busy,
`ifdef FG_COUNT_EN
  output logic             done,
  output logic [CNT_W-1:0] fg_count
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [2:0]       gather_q, gather_d;
  logic [3:0]       pix_out_q, pix_out_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, xfer, result, last_pix;

  // Only lane 3 can stall: lanes 0-2 land in the gather register, lane 3 needs the output slot.
  assign s_ready  = (state_q == RUN) && ((lane_q != 2'd3) || !m_valid_q || m_ready);
  assign accept   = s_valid && s_ready;
  assign xfer     = m_valid_q && m_ready;
  assign result   = (s_pixel >= thr_q);
  assign last_pix = (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    pix_cnt_d = pix_cnt_q;
    thr_d     = thr_q;
    gather_d  = gather_q;
    pix_out_d = pix_out_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_d     = threshold;
          lane_d    = '0;
          pix_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          case (lane_q)
            2'd0:    gather_d[0] = result;
            2'd1:    gather_d[1] = result;
            2'd2:    gather_d[2] = result;
            default: ;
          endcase
          lane_d    = lane_q + 2'd1;
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (last_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && m_last_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A lane-3 load takes priority over a plain drain so back-to-back groups keep m_valid high.
    if (accept && (lane_q == 2'd3)) begin
      m_valid_d = 1'b1;
      pix_out_d = {result, gather_q};
      m_last_d  = last_pix;
    end else if (xfer) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      pix_cnt_q <= '0;
      thr_q     <= '0;
      gather_q  <= '0;
      pix_out_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      pix_cnt_q <= pix_cnt_d;
      thr_q     <= thr_d;
      gather_q  <= gather_d;
      pix_out_q <= pix_out_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_out_0 = pix_out_q[0];
  assign pixel_out_1 = pix_out_q[1];
  assign pixel_out_2 = pix_out_q[2];
  assign pixel_out_3 = pix_out_q[3];

`ifdef FG_COUNT_EN
  logic [CNT_W-1:0] fg_count_q, fg_count_d;

  always_comb begin
    fg_count_d = fg_count_q;
    if ((state_q == IDLE) && start) fg_count_d = '0;
    else if ((state_q == RUN) && accept && result) fg_count_d = fg_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fg_count_q <= '0;
    else          fg_count_q <= fg_count_d;
  end

  assign fg_count = fg_count_q;
`endif

endmodule

// File: tb/tb_threshold_gather.sv
// Directed and randomized frames for threshold_gather with an 8-pixel frame, checked against a list-based model.
module tb_threshold_gather;
  localparam int PIX_W = 8;
  localparam int FP    = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [PIX_W-1:0] threshold = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [PIX_W-1:0] s_pixel = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic pixel_out_0, pixel_out_1, pixel_out_2, pixel_out_3;
  logic m_last, busy, done;
`ifdef FG_COUNT_EN
  logic [CNT_W-1:0] fg_count;
`endif

  threshold_gather #(.PIX_W(PIX_W), .FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .threshold(threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .m_valid(m_valid), .m_ready(m_ready),
    .pixel_out_0(pixel_out_0), .pixel_out_1(pixel_out_1),
    .pixel_out_2(pixel_out_2), .pixel_out_3(pixel_out_3),
    .m_last(m_last), .busy(busy),
`ifdef FG_COUNT_EN
    .done(done), .fg_count(fg_count)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [PIX_W-1:0] pix [FP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {pixel_out_3, pixel_out_2, pixel_out_1, pixel_out_0};
  endfunction

  // mode 0: always ready; 1: downstream blocked for the first 10 cycles; 2: random valid/ready
  task automatic run_frame(input logic [PIX_W-1:0] thr, input int mode);
    logic [3:0] exp_grp [2];
    int exp_fg, sent, groups, cyc;
    logic acc, xfr, held;
    logic [4:0] held_val;
    exp_fg = 0;
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 4; k++) begin
        exp_grp[g][k] = (pix[g*4+k] >= thr);
        if (pix[g*4+k] >= thr) exp_fg++;
      end
    @(negedge clk);
    start = 1'b1; threshold = thr; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
`ifdef FG_COUNT_EN
    chk("fg_cleared_on_start", fg_count, 0);
`endif
    sent = 0; groups = 0; cyc = 0; held = 1'b0; held_val = '0;
    while (groups < 2 && cyc < 300) begin
      @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc >= 10);
        default: m_ready = 1'($urandom % 2);
      endcase
      s_valid   = (mode == 2) ? ($urandom % 3 != 0) : 1'b1;
      s_pixel   = (sent < FP) ? pix[sent] : PIX_W'($urandom);
      threshold = PIX_W'($urandom);
      start     = busy && ($urandom % 4 == 0);
      #1;
      acc = s_valid && s_ready;
      xfr = m_valid && m_ready;
      if (sent >= FP) chk("no_extra_accept", s_ready, 0);
      else if ((sent % 4 == 3) && m_valid && !m_ready) chk("stall_lane3", s_ready, 0);
      else chk("ready_run", s_ready, 1);
      if (held) chk("hold_stable", {m_valid, m_last, outs()}, {1'b1, held_val});
      held     = m_valid && !m_ready;
      held_val = {m_last, outs()};
      if (xfr) begin
        chk("group", outs(), exp_grp[groups]);
        chk("m_last", m_last, (groups == 1));
        groups++;
      end
      if (acc) sent++;
      cyc++;
      @(posedge clk);
    end
    start = 1'b0; s_valid = 1'b0;
    if (groups < 2) chk("timeout", 0, 1);
    chk("pixels_accepted", sent, FP);
    @(negedge clk); chk("done_not_yet", done, 0);
    @(negedge clk); chk("done_pulse", done, 1); chk("busy_idle", busy, 0);
`ifdef FG_COUNT_EN
    chk("fg_count", fg_count, exp_fg);
`endif
    @(negedge clk); chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", outs(), 0);
`ifdef FG_COUNT_EN
    chk("rst_fg", fg_count, 0);
`endif
    @(negedge clk); reset_n = 1'b1;

    pix[0] = 8'd0;   pix[1] = 8'd127; pix[2] = 8'd128; pix[3] = 8'd255;
    pix[4] = 8'd200; pix[5] = 8'd50;  pix[6] = 8'd128; pix[7] = 8'd129;
    run_frame(8'd128, 0);
    run_frame(8'd128, 1);

    for (int i = 0; i < FP; i++) pix[i] = '0;
    run_frame(8'd0, 0);
    for (int i = 0; i < FP; i++) pix[i] = (i % 2 == 0) ? 8'd254 : 8'd255;
    run_frame(8'd255, 2);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FP; i++) pix[i] = PIX_W'($urandom);
      run_frame(PIX_W'($urandom), 2);
    end

    // Abort mid-frame: one group waiting downstream plus a partial second group.
    @(negedge clk);
    start = 1'b1; threshold = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_pixel = 8'd255; m_ready = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_abort_m_valid", m_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_outs", outs(), 0);
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_m_last", m_last, 0);
    s_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    pix[0] = 8'd10; pix[1] = 8'd90; pix[2] = 8'd91; pix[3] = 8'd5;
    pix[4] = 8'd255; pix[5] = 8'd0; pix[6] = 8'd100; pix[7] = 8'd89;
    run_frame(8'd90, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
